// File: rtl/counter_ctrl.sv
// Window controller for an external 4-bit counter: enables it for a set number of
// increments, then checks that it advanced by exactly that amount.
module counter_ctrl #(
  parameter int RUNW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      len,
  input  logic            periodic,
  input  logic            abort,
  input  logic [3:0]      cnt_count,
  output logic            cnt_en,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [RUNW-1:0] run_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_base;
  logic [4:0]      r_len;
  logic [4:0]      r_rem;
  logic            r_mode;
  logic            r_cnt_en;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [RUNW-1:0] r_run_cnt;

  logic [4:0]      w_len;
  logic [3:0]      w_delta;
  logic            w_match;

  // A length field of zero stands for a full 16-increment window.
  assign w_len   = (len == 4'd0) ? 5'd16 : {1'b0, len};
  assign w_delta = cnt_count - r_base;
  assign w_match = (w_delta == r_len[3:0]);

  assign cnt_en  = r_cnt_en;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign run_cnt = r_run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= 4'd0;
      r_len     <= 5'd0;
      r_rem     <= 5'd0;
      r_mode    <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_base   <= cnt_count;
            r_len    <= w_len;
            r_mode   <= periodic;
            r_rem    <= w_len;
            r_err    <= 1'b0;
            r_cnt_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_rem <= r_rem - 5'd1;
            if (r_rem == 5'd1) begin
              r_cnt_en <= 1'b0;
              r_state  <= CHECK;
            end
          end
        end
        CHECK: begin
          if (abort) begin
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_done <= 1'b1;
            if (r_run_cnt != {RUNW{1'b1}}) begin
              r_run_cnt <= r_run_cnt + {{(RUNW-1){1'b0}}, 1'b1};
            end
            if (!w_match) begin
              r_err <= 1'b1;
            end
            // Periodic mode re-arms from wherever the counter now sits.
            if (r_mode) begin
              r_base   <= cnt_count;
              r_rem    <= r_len;
              r_cnt_en <= 1'b1;
              r_state  <= RUN;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_cnt_en <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a behavioural 4-bit counter follows cnt_en, and a
// second instance with RUNW=2 shares the stimulus to exercise run_cnt saturation.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       periodic;
  logic       abort;
  logic       freeze;
  logic       loadEn;
  logic [3:0] loadVal;

  logic [3:0] cntA;
  logic       cntEnA, busyA, doneA, errA;
  logic [7:0] runA;
  logic [3:0] cntB;
  logic       cntEnB, busyB, doneB, errB;
  logic [1:0] runB;

  int nCompared = 0;
  int nMismatch = 0;
  int expRun    = 0;

  typedef struct {
    logic [3:0] init;
    logic [3:0] len;
    logic       freeze;
    logic [3:0] expCnt;
    logic       expErr;
    int         expHigh;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  counter_ctrl #(.RUNW(8)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .periodic(periodic),
    .abort(abort), .cnt_count(cntA), .cnt_en(cntEnA), .busy(busyA),
    .done(doneA), .err(errA), .run_cnt(runA)
  );

  counter_ctrl #(.RUNW(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .periodic(periodic),
    .abort(abort), .cnt_count(cntB), .cnt_en(cntEnB), .busy(busyB),
    .done(doneB), .err(errB), .run_cnt(runB)
  );

  // Controlled counters; freeze models a counter that ignores its enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cntA <= 4'd0;
    else if (loadEn) cntA <= loadVal;
    else if (cntEnA && !freeze) cntA <= cntA + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cntB <= 4'd0;
    else if (loadEn) cntB <= loadVal;
    else if (cntEnB && !freeze) cntB <= cntB + 4'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadCounter(input logic [3:0] v, input logic frz);
    @(negedge clk);
    loadEn  = 1'b1;
    loadVal = v;
    freeze  = frz;
    @(negedge clk);
    loadEn  = 1'b0;
  endtask

  // Presents a start for one edge; returns at the first negedge after acceptance.
  task automatic applyStimulus(input logic [3:0] l, input logic per);
    start    = 1'b1;
    len      = l;
    periodic = per;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    int high, doneCnt, doneAt, winLen;
    logic prevErr;
    logic [3:0] expEn [6];

    vecs[0] = '{init: 4'd0,  len: 4'd5, freeze: 1'b0, expCnt: 4'd5, expErr: 1'b0, expHigh: 5};
    vecs[1] = '{init: 4'd9,  len: 4'd0, freeze: 1'b0, expCnt: 4'd9, expErr: 1'b0, expHigh: 16};
    vecs[2] = '{init: 4'd4,  len: 4'd2, freeze: 1'b1, expCnt: 4'd4, expErr: 1'b1, expHigh: 2};
    vecs[3] = '{init: 4'd15, len: 4'd3, freeze: 1'b0, expCnt: 4'd2, expErr: 1'b0, expHigh: 3};
    vecs[4] = '{init: 4'd7,  len: 4'd1, freeze: 1'b0, expCnt: 4'd8, expErr: 1'b0, expHigh: 1};

    rst_n = 1'b0; start = 1'b0; len = 4'd0; periodic = 1'b0; abort = 1'b0;
    freeze = 1'b0; loadEn = 1'b0; loadVal = 4'd0;
    #2;
    checkOutput("rst_cnt_en", cntEnA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_err", errA, 0);
    checkOutput("rst_run_cnt", runA, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot windows from the table.
    prevErr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loadCounter(vecs[i].init, vecs[i].freeze);
      checkOutput("err_sticky_idle", errA, prevErr);
      applyStimulus(vecs[i].len, 1'b0);
      checkOutput("err_clear_on_start", errA, 0);
      checkOutput("busy_rise", busyA, 1);
      winLen = (vecs[i].len == 4'd0) ? 16 : int'(vecs[i].len);
      high = 0; doneCnt = 0; doneAt = 0;
      for (int k = 1; k <= winLen + 3; k++) begin
        if (k > 1) @(negedge clk);
        if (cntEnA) high++;
        if (doneA) begin doneCnt++; doneAt = k; end
      end
      expRun++;
      checkOutput("win_en_cycles", high, vecs[i].expHigh);
      checkOutput("win_done_count", doneCnt, 1);
      checkOutput("win_done_time", doneAt, winLen + 2);
      checkOutput("win_cnt_final", cntA, vecs[i].expCnt);
      checkOutput("win_err", errA, vecs[i].expErr);
      checkOutput("win_busy_after", busyA, 0);
      checkOutput("win_run_cnt", runA, expRun);
      prevErr = vecs[i].expErr;
    end

    // Periodic len=3, aborted during the second window.
    expEn = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    loadCounter(4'd0, 1'b0);
    applyStimulus(4'd3, 1'b1);
    doneCnt = 0; doneAt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput($sformatf("per_en_k%0d", k), cntEnA, expEn[k-1]);
      if (doneA) begin doneCnt++; doneAt = k; end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("per_abort_en", cntEnA, 0);
    checkOutput("per_abort_busy", busyA, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (doneA) doneCnt++;
    end
    expRun++;
    checkOutput("per_done_count", doneCnt, 1);
    checkOutput("per_done_time", doneAt, 5);
    checkOutput("per_cnt_final", cntA, 5);
    checkOutput("per_run_cnt", runA, expRun);

    // Periodic len=2: done every 3 cycles until abort.
    loadCounter(4'd0, 1'b0);
    applyStimulus(4'd2, 1'b1);
    doneCnt = 0; doneAt = 0; high = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (cntEnA) high++;
      if (doneA) begin
        doneCnt++;
        checkOutput("per2_done_spacing", k - doneAt, (doneAt == 0) ? 4 : 3);
        doneAt = k;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expRun += 3;
    checkOutput("per2_done_count", doneCnt, 3);
    checkOutput("per2_en_cycles", high, 7);
    checkOutput("per2_run_cnt", runA, expRun);

    // Abort while in CHECK suppresses completion.
    loadCounter(4'd0, 1'b0);
    applyStimulus(4'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("chk_abort_done", doneA, 0);
    checkOutput("chk_abort_busy", busyA, 0);
    doneCnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (doneA) doneCnt++;
    end
    checkOutput("chk_abort_no_done", doneCnt, 0);
    checkOutput("chk_abort_run_cnt", runA, expRun);

    // Start together with abort in IDLE is refused.
    start = 1'b1; abort = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_busy", busyA, 0);
    checkOutput("start_abort_en", cntEnA, 0);

    // Start pulsed mid-window with different len/periodic is ignored.
    loadCounter(4'd0, 1'b0);
    applyStimulus(4'd4, 1'b0);
    high = 0; doneCnt = 0; doneAt = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (cntEnA) high++;
      if (doneA) begin doneCnt++; doneAt = k; end
      if (k == 2) begin start = 1'b1; len = 4'd1; periodic = 1'b1; end
      if (k == 3) begin start = 1'b0; periodic = 1'b0; end
    end
    expRun++;
    checkOutput("run_start_en_cycles", high, 4);
    checkOutput("run_start_done_count", doneCnt, 1);
    checkOutput("run_start_done_time", doneAt, 6);
    checkOutput("run_start_busy", busyA, 0);
    checkOutput("run_start_cnt", cntA, 4);
    checkOutput("run_start_run_cnt", runA, expRun);

    // Asynchronous reset mid-window, asserted between clock edges.
    loadCounter(4'd0, 1'b0);
    applyStimulus(4'd8, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_en", cntEnA, 0);
    checkOutput("async_rst_busy", busyA, 0);
    checkOutput("async_rst_done", doneA, 0);
    checkOutput("async_rst_err", errA, 0);
    checkOutput("async_rst_run_cnt", runA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expRun = 0;
    high = 0; doneCnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cntEnA || busyA) high++;
      if (doneA) doneCnt++;
    end
    checkOutput("post_rst_idle", high, 0);
    checkOutput("post_rst_no_done", doneCnt, 0);

    // Five windows: RUNW=2 instance saturates at 3.
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(4'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      expRun++;
      checkOutput($sformatf("sat_runB_w%0d", w), runB, (w > 3) ? 3 : w);
    end
    checkOutput("sat_runA", runA, expRun);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter RUNW, default 8: width of the completed-window counter run_cnt.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one counting window; sampled only in IDLE.
REQ-005 len  input  4  window length in counter increments; 1..15 literal, 0 means 16.
REQ-006 periodic  input  1  sampled with start; 1 = re-arm windows back-to-back until abort.
REQ-007 abort  input  1  terminate the active window or sequence.
REQ-008 cnt_count  input  4  current value of the controlled 4-bit counter.
REQ-009 cnt_en  output  1  registered enable to the counter; the counter increments on every edge where cnt_en=1.
REQ-010 busy  output  1  registered; 1 whenever state != IDLE.
REQ-011 done  output  1  registered single-cycle pulse per completed window.
REQ-012 err  output  1  sticky mismatch flag.
REQ-013 run_cnt  output  RUNW  count of completed windows; saturates at all-ones.

Function
REQ-014 FSM states: IDLE, RUN, CHECK.
REQ-015 IDLE, start=1, abort=0 at edge E0: latch base<=cnt_count, L<=len (0 -> 16), mode<=periodic, rem<=L, err<=0, cnt_en<=1, state<=RUN.
REQ-016 start while busy is ignored; len and periodic are not re-sampled mid-sequence.
REQ-017 RUN: rem decrements every edge; at the edge where rem==1: cnt_en<=0, state<=CHECK; cnt_en is high for exactly L cycles (E0..E_L).
REQ-018 CHECK, one cycle: compute (cnt_count - base) mod 16 using 4-bit wrap arithmetic; compare against L mod 16 (L=16 compares to 0).
REQ-019 CHECK exit edge: done<=1 for one cycle; run_cnt<=run_cnt+1 unless all-ones; err<=1 on mismatch, otherwise err unchanged.
REQ-020 CHECK exit with mode=1 and abort=0: base<=cnt_count, rem<=L, cnt_en<=1, state<=RUN; this gives an L-high/1-low cnt_en pattern and a done every L+1 cycles.
REQ-021 CHECK exit with mode=0: state<=IDLE, cnt_en stays 0.
REQ-022 abort=1 at any edge in RUN or CHECK: state<=IDLE, cnt_en<=0, no done pulse, run_cnt and err unchanged.
REQ-023 abort has priority over start and over CHECK completion; start+abort in IDLE leaves the block in IDLE.
REQ-024 abort in IDLE has no effect.
REQ-025 busy rises on the edge that accepts start and falls on the edge that enters IDLE.

Reset
REQ-026 rst_n=0 forces immediately, regardless of clk: state=IDLE, cnt_en=0, busy=0, done=0, err=0, run_cnt=0, base=0, rem=0.
REQ-027 Reset mid-window discards the window: no done, no run_cnt update; after release the block waits in IDLE for a new start.

Verification
REQ-028 Reset: assert rst_n=0 mid-RUN between clock edges -> cnt_en, busy, done, err, run_cnt all 0 without waiting for an edge.
REQ-029 One-shot: counter at 0, start with len=5, periodic=0 -> cnt_en high 5 cycles, cnt_count=5, done pulses once the cycle after cnt_en falls, err=0, run_cnt=1, busy=0 afterwards.
REQ-030 Wrap: counter at 9, start with len=0 -> cnt_en high 16 cycles, cnt_count returns to 9, err=0, done once.
REQ-031 Periodic: len=3, periodic=1 -> cnt_en pattern 1,1,1,0 repeating; done every 4 cycles; abort during the 2nd window -> cnt_en=0 next edge, no further done, run_cnt=1.
REQ-032 Error: model a counter that ignores cnt_en (cnt_count fixed at 4), start with len=2 -> done pulses, err=1, err stays 1 until the next accepted start.
REQ-033 Corners: start+abort in IDLE -> busy stays 0; start pulsed during RUN -> ignored; with RUNW=2, 5 windows -> run_cnt saturates at 3.
